dcache_line_memory: RTL and testbench
=====================================

// Module: dcache_line_memory
// PURPOSE
//  Parametrised line-granular backing memory behind the data cache; serves whole-line reads/writes.
//  Transfers BEAT_BYTES per clock over LINE_BYTES/BEAT_BYTES beats after an optional access latency.
//  Request is latched at accept; a one-cycle response state closes the busywait handshake.
//  Out-of-range lines raise an error flag instead of aliasing.
// PARAMETERS
//  ADDR_WIDTH      28  line-address width (byte address = {address, log2(LINE_BYTES) zeros})
//  LINE_BYTES      16  bytes per cache line; power of two, >=1
//  BEAT_BYTES      1   bytes moved per clock; power of two, divides LINE_BYTES
//  MEM_LINES       64  lines implemented (64*16 = 1024 bytes default)
//  ACCESS_LATENCY  0   idle cycles between accept and first beat
// PORTS
//  clock      in   1               sole clock, all state on posedge
//  reset      in   1               synchronous, active-high
//  read       in   1               line read request, held until busywait low
//  write      in   1               line write request, held until busywait low
//  address    in   ADDR_WIDTH      line address
//  writedata  in   8*LINE_BYTES    write line; byte i at bits [8i+7:8i]
//  readdata   out  8*LINE_BYTES    read line, valid from RESP cycle onward
//  busywait   out  1               high while a valid request is outstanding
//  error      out  1               high in RESP cycle iff latched address >= MEM_LINES
// BEHAVIOUR
//  Reset (reset high at posedge): state=IDLE, beat/latency counters=0, readdata=0, error=0.
//   busywait forced 0 while reset high. Array contents not cleared. Mid-op reset aborts:
//   beats already written stay written; no further beats; readdata=0.
//  busywait (combinational) = !reset && (read ^ write) && state != RESP.
//  read && write both high: illegal, treated as no request (busywait 0, IDLE held).
//  FSM IDLE -> WAIT -> XFER -> RESP -> IDLE:
//   IDLE: on posedge with read^write: latch op, address, writedata; clear beat=0;
//    ACCESS_LATENCY>0 -> WAIT with lat=ACCESS_LATENCY-1, else -> XFER.
//   WAIT: lat decrements; lat==0 at posedge -> XFER.
//   XFER: one beat per posedge on bytes [beat*BEAT_BYTES +: BEAT_BYTES];
//    write: array <= latched writedata lanes; read: internal buffer <= array lanes.
//    beat==BEATS-1 -> RESP; BEATS = LINE_BYTES/BEAT_BYTES.
//   RESP (exactly 1 cycle): busywait low; readdata = buffer (read only; write leaves readdata
//    unchanged); error set if out of range; next posedge -> IDLE, error cleared.
//  Latency: busywait high for ACCESS_LATENCY+BEATS+1 cycles incl. accept cycle; default 17.
//  readdata changes only on the posedge entering RESP of a read; stable otherwise.
//  Input changes after accept ignored until IDLE. Back-to-back: new request may be
//   accepted on the posedge leaving... no: the posedge leaving RESP goes IDLE; next posedge accepts.
//  Out of range: full latency still spent, no array write, read returns all zeros.
//  Beat counter wraps only via FSM exit; never indexes beyond LINE_BYTES.
// TESTING
//  T1 defaults, write line 0x0F0E..0100 to line 3, then read line 3 -> readdata equal, busywait 17 cyc each.
//  T2 BEAT_BYTES=4, ACCESS_LATENCY=2: read -> busywait high exactly 2+4+1=7 cycles, data correct.
//  T3 read of line 64 (MEM_LINES=64) -> error=1 for 1 cycle, readdata=0, line 0 unmodified after write to 64.
//  T4 reset asserted at beat 5 of write to line 2 -> IDLE next cycle, bytes 0..4 new, 5..15 old, readdata=0.
//  T5 read&&write both high -> busywait 0, state stays IDLE, no array change over 20 cycles.
//  T6 change address/writedata mid-transaction -> result uses values latched at accept.

Source files
------------

// File: rtl/dcache_line_memory.sv
// dcache_line_memory
//   Line-granular backing store behind the data cache. A whole line is moved
//   BEAT_BYTES per clock over BEATS beats, after ACCESS_LATENCY idle cycles.
//   The request is latched when it is accepted. A single RESP cycle then drops
//   busywait so that the requester can release its request.
//
// Ports
//   clock      sole clock, all state on posedge
//   reset      synchronous, active-high
//   read       line read request, held until busywait low
//   write      line write request, held until busywait low
//   address    line address
//   writedata  line to write; byte i at bits [8i+7:8i]
//   readdata   last line read; updated on entry to RESP of a read
//   busywait   high while a valid request is outstanding
//   error      high during RESP when the latched line is out of range
//
// state  | meaning
// S_IDLE | waiting for read ^ write; latches the request on accept
// S_WAIT | access latency countdown (lat_q down to 0)
// S_XFER | one beat per clock; beat_q selects the lanes
// S_RESP | one cycle, busywait low, readdata/error presented
module dcache_line_memory #(
  parameter int ADDR_WIDTH     = 28,
  parameter int LINE_BYTES     = 16,
  parameter int BEAT_BYTES     = 1,
  parameter int MEM_LINES      = 64,
  parameter int ACCESS_LATENCY = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    read,
  input  logic                    write,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [8*LINE_BYTES-1:0] writedata,
  output logic [8*LINE_BYTES-1:0] readdata,
  output logic                    busywait,
  output logic                    error
);

  localparam int BEATS     = LINE_BYTES / BEAT_BYTES;
  localparam int BEAT_BITS = 8 * BEAT_BYTES;
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LAT_W     = (ACCESS_LATENCY > 0) ? $clog2(ACCESS_LATENCY + 1) : 1;
  localparam int IDX_W     = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;

  // A line viewed as an array of beats; beat 0 occupies the lowest bytes.
  typedef logic [BEATS-1:0][BEAT_BITS-1:0] line_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_RESP} state_t;

  state_t                  state, state_nxt;
  logic                    req;
  logic                    op_read_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  line_t                   wdata_q;
  line_t                   rbuf_q;
  line_t                   rbuf_nxt;
  line_t                   rdata_q;
  logic [BEAT_W-1:0]       beat_q;
  logic [LAT_W-1:0]        lat_q;
  logic                    error_q;
  logic                    in_range;
  logic                    last_beat;
  logic [IDX_W-1:0]        idx;
  logic [BEAT_BITS-1:0]    rd_beat;

  line_t mem [MEM_LINES];

  assign req       = read ^ write;
  assign busywait  = !reset && req && (state != S_RESP);
  assign in_range  = ({1'b0, addr_q} < (ADDR_WIDTH+1)'(MEM_LINES));
  assign idx       = addr_q[IDX_W-1:0];
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
  assign readdata  = rdata_q;
  assign error     = error_q;

  // Out-of-range lines read as zeros rather than aliasing onto a real line.
  assign rd_beat = in_range ? mem[idx][beat_q] : '0;

  // The final beat lands in the buffer on the same edge readdata is loaded,
  // so readdata takes the buffer with the current beat merged in.
  always_comb begin
    rbuf_nxt         = rbuf_q;
    rbuf_nxt[beat_q] = rd_beat;
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req) state_nxt = (ACCESS_LATENCY > 0) ? S_WAIT : S_XFER;
      S_WAIT: if (lat_q == '0) state_nxt = S_XFER;
      S_XFER: if (last_beat) state_nxt = S_RESP;
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      beat_q  <= '0;
      lat_q   <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            op_read_q <= read;
            addr_q    <= address;
            wdata_q   <= writedata;
            beat_q    <= '0;
            lat_q     <= LAT_W'((ACCESS_LATENCY > 0) ? ACCESS_LATENCY - 1 : 0);
          end
        end
        S_WAIT: begin
          if (lat_q != '0) lat_q <= lat_q - 1'b1;
        end
        S_XFER: begin
          if (op_read_q) rbuf_q <= rbuf_nxt;
          else if (in_range) mem[idx][beat_q] <= wdata_q[beat_q];
          if (last_beat) begin
            beat_q  <= '0;
            error_q <= !in_range;
            if (op_read_q) rdata_q <= rbuf_nxt;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        S_RESP: begin
          error_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_line_memory.sv
module tb_dcache_line_memory;

  localparam int ADDR_WIDTH = 28;
  localparam int LINE_BYTES = 16;
  localparam int BEAT_BYTES = 2;
  localparam int MEM_LINES  = 64;
  localparam int ACC_LAT    = 2;
  localparam int BEATS      = LINE_BYTES / BEAT_BYTES;
  localparam int EXP_BUSY   = ACC_LAT + BEATS + 1;

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    read;
  logic                    write;
  logic [ADDR_WIDTH-1:0]   address;
  logic [8*LINE_BYTES-1:0] writedata;
  logic [8*LINE_BYTES-1:0] readdata;
  logic                    busywait;
  logic                    error;

  dcache_line_memory #(
    .ADDR_WIDTH(ADDR_WIDTH), .LINE_BYTES(LINE_BYTES), .BEAT_BYTES(BEAT_BYTES),
    .MEM_LINES(MEM_LINES), .ACCESS_LATENCY(ACC_LAT)
  ) dut (
    .clock(clock), .reset(reset), .read(read), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata),
    .busywait(busywait), .error(error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic         is_read;
    logic [127:0] rdata;
    logic         err;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] ref_mem [MEM_LINES];
  logic [127:0] last_rd;
  int           n_cmp = 0;
  int           n_bad = 0;
  int           busy_cnt = 0;

  function automatic logic [127:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Monitor: a held request with busywait low is the response cycle.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (busywait) busy_cnt++;
      if ((read ^ write) && !busywait) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_response: no transaction pending");
        end else begin
          e = sb.pop_front();
          if (busy_cnt != EXP_BUSY) begin
            n_bad++;
            $display("FAIL busy_cycles: got %0d want %0d", busy_cnt, EXP_BUSY);
          end
          n_cmp++;
          if (error !== e.err) begin
            n_bad++;
            $display("FAIL error_flag: got %0b want %0b", error, e.err);
          end
          n_cmp++;
          if (readdata !== e.rdata) begin
            n_bad++;
            $display("FAIL readdata(%s): got %h want %h", e.is_read ? "read" : "write",
                     readdata, e.rdata);
          end
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic do_txn(input bit is_rd, input int addr, input logic [127:0] data,
                        input bit scramble);
    exp_t e;
    bit   done;
    @(posedge clock); #1;
    read      = is_rd;
    write     = !is_rd;
    address   = ADDR_WIDTH'(addr);
    writedata = data;
    e.is_read = is_rd;
    e.err     = (addr >= MEM_LINES);
    if (is_rd) begin
      e.rdata = (addr < MEM_LINES) ? ref_mem[addr] : '0;
      last_rd = e.rdata;
    end else begin
      if (addr < MEM_LINES) ref_mem[addr] = data;
      e.rdata = last_rd;
    end
    sb.push_back(e);
    if (scramble) begin
      @(posedge clock); #1;
      address   = ADDR_WIDTH'($urandom_range(0, MEM_LINES - 1));
      writedata = rand_line();
    end
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clock);
      if (!busywait) done = 1;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL txn_timeout: busywait still %0b after 100 cycles, want 0", busywait);
    end
    @(posedge clock); #1;
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] d;
    reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    last_rd = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_readdata", readdata, '0);
    chk("reset_busywait", {127'd0, busywait}, '0);
    chk("reset_error", {127'd0, error}, '0);
    @(posedge clock); #1 reset = 1'b0;

    for (int i = 0; i < MEM_LINES; i++) do_txn(1'b0, i, rand_line(), 1'b0);

    // Known pattern write/read to line 3
    do_txn(1'b0, 3, 128'h0F0E0D0C0B0A09080706050403020100, 1'b0);
    do_txn(1'b1, 3, '0, 1'b0);

    // Out of range: read returns zero with error, write does not alias line 0
    do_txn(1'b1, MEM_LINES, '0, 1'b0);
    do_txn(1'b0, MEM_LINES, rand_line(), 1'b0);
    do_txn(1'b1, 0, '0, 1'b0);

    // Inputs changed after accept are ignored
    do_txn(1'b0, 7, rand_line(), 1'b1);
    do_txn(1'b1, 7, '0, 1'b1);
    do_txn(1'b1, 7, '0, 1'b0);

    // Reset during the write of line 2, just before beat 5 is written
    d = rand_line();
    @(posedge clock); #1;
    write = 1'b1; address = ADDR_WIDTH'(2); writedata = d;
    repeat (8) @(posedge clock);
    #1 reset = 1'b1; write = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("abort_readdata", readdata, '0);
    chk("abort_busywait", {127'd0, busywait}, '0);
    ref_mem[2] = {ref_mem[2][127:80], d[79:0]};
    last_rd = '0;
    @(posedge clock); #1 reset = 1'b0;
    do_txn(1'b1, 2, '0, 1'b0);

    // read && write together is no request
    @(posedge clock); #1;
    read = 1'b1; write = 1'b1; address = ADDR_WIDTH'(5); writedata = rand_line();
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("both_busywait", {127'd0, busywait}, '0);
    end
    @(posedge clock); #1 read = 1'b0; write = 1'b0;
    do_txn(1'b1, 5, '0, 1'b0);

    for (int i = 0; i < 80; i++)
      do_txn(1'($urandom_range(0, 1)), int'($urandom_range(0, MEM_LINES + 5)),
             rand_line(), 1'($urandom_range(0, 1)));

    repeat (5) @(posedge clock);
    chk("scoreboard_drained", 128'(sb.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
